// File: rtl/seg7_history_display.sv
// Four-digit seven-segment history display: debounced capture/clear buttons,
// a four-entry shift history of accepted codes, and a multiplexed digit scan.

module seg7_history_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic pulse
);
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  logic             lvl_q, lvl_d;
  logic             lvl_prev_q, lvl_prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      lvl_q      <= 1'b0;
      lvl_prev_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      sync_q     <= sync_d;
      lvl_q      <= lvl_d;
      lvl_prev_q <= lvl_prev_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    sync_d     = {sync_q[0], btn_raw};
    lvl_d      = lvl_q;
    cnt_d      = cnt_q;
    lvl_prev_d = lvl_q;
    // Any return to the accepted level restarts the stability count.
    if (sync_q[1] == lvl_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      lvl_d = sync_q[1];
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign pulse = lvl_q & ~lvl_prev_q;
endmodule

module seg7_history_display #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REFRESH_DIV     = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] code,
  input  logic       btn_capture,
  input  logic       btn_clear,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);
  localparam int unsigned RC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(REFRESH_DIV - 1);

  logic            cap_pulse, clr_pulse;
  logic [3:0]      h_q [4];
  logic [3:0]      h_d [4];
  logic [2:0]      cnt_v_q, cnt_v_d;
  logic            err_q, err_d;
  logic [RC_W-1:0] rc_q, rc_d;
  logic [1:0]      sel_q, sel_d;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;

  seg7_history_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_capture (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_raw(btn_capture),
    .pulse  (cap_pulse)
  );

  seg7_history_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_raw(btn_clear),
    .pulse  (clr_pulse)
  );

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 4; i++) h_q[i] <= '0;
      cnt_v_q <= '0;
      err_q   <= 1'b0;
      rc_q    <= '0;
      sel_q   <= '0;
      an_q    <= '1;
      seg_q   <= '1;
      dp_q    <= 1'b1;
    end else begin
      for (int unsigned i = 0; i < 4; i++) h_q[i] <= h_d[i];
      cnt_v_q <= cnt_v_d;
      err_q   <= err_d;
      rc_q    <= rc_d;
      sel_q   <= sel_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) h_d[i] = h_q[i];
    cnt_v_d = cnt_v_q;
    err_d   = err_q;
    // Clear takes priority; a coincident capture is dropped.
    if (clr_pulse) begin
      for (int unsigned i = 0; i < 4; i++) h_d[i] = '0;
      cnt_v_d = '0;
      err_d   = 1'b0;
    end else if (cap_pulse) begin
      if (code != 4'h0) begin
        h_d[3]  = h_q[2];
        h_d[2]  = h_q[1];
        h_d[1]  = h_q[0];
        h_d[0]  = code;
        cnt_v_d = (cnt_v_q == 3'd4) ? 3'd4 : cnt_v_q + 3'd1;
        err_d   = 1'b0;
      end else begin
        err_d   = 1'b1;
      end
    end
  end

  always_comb begin
    rc_d  = rc_q + 1'b1;
    sel_d = sel_q;
    if (rc_q == RC_LAST) begin
      rc_d  = '0;
      sel_d = sel_q + 2'd1;
    end
  end

  always_comb begin
    an_d  = ~(4'b0001 << sel_q);
    seg_d = ({1'b0, sel_q} < cnt_v_q) ? hex_to_seg(h_q[sel_q]) : '1;
    dp_d  = ~((sel_q == 2'd0) & err_q);
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;
endmodule
